// File: rtl/memory_if_arbiter_if.sv
// Bundle of master-side request/return signals and the memory_if CPU-side port.
// Pure wiring, no latency; all handshakes are BUSY-style (holder keeps request while BUSY).
// slave modport = arbiter view, master modport = view of whatever drives the arbiter.
interface memory_if_arbiter_if;
    // Master 0 (instruction fetch)
    logic        iM0_REQ;
    logic        oM0_BUSY;
    logic [3:0]  iM0_MASK;
    logic        iM0_RW;
    logic [31:0] iM0_ADDR;
    logic [31:0] iM0_DATA;
    logic        oM0_VALID;
    logic        iM0_BUSY;
    logic [63:0] oM0_DATA;
    // Master 1 (load/store)
    logic        iM1_REQ;
    logic        oM1_BUSY;
    logic [3:0]  iM1_MASK;
    logic        iM1_RW;
    logic [31:0] iM1_ADDR;
    logic [31:0] iM1_DATA;
    logic        oM1_VALID;
    logic        iM1_BUSY;
    logic [63:0] oM1_DATA;
    // memory_if CPU-side port
    logic        oMIF_REQ;
    logic [3:0]  oMIF_MASK;
    logic        oMIF_RW;
    logic [31:0] oMIF_ADDR;
    logic [31:0] oMIF_DATA;
    logic        iMIF_BUSY;
    logic        iMIF_VALID;
    logic [63:0] iMIF_DATA;
    logic        oMIF_BUSY;
    logic        oARB_ERROR;

    modport slave (
        input  iM0_REQ, iM0_MASK, iM0_RW, iM0_ADDR, iM0_DATA, iM0_BUSY,
        output oM0_BUSY, oM0_VALID, oM0_DATA,
        input  iM1_REQ, iM1_MASK, iM1_RW, iM1_ADDR, iM1_DATA, iM1_BUSY,
        output oM1_BUSY, oM1_VALID, oM1_DATA,
        output oMIF_REQ, oMIF_MASK, oMIF_RW, oMIF_ADDR, oMIF_DATA, oMIF_BUSY,
        input  iMIF_BUSY, iMIF_VALID, iMIF_DATA,
        output oARB_ERROR
    );

    modport master (
        output iM0_REQ, iM0_MASK, iM0_RW, iM0_ADDR, iM0_DATA, iM0_BUSY,
        input  oM0_BUSY, oM0_VALID, oM0_DATA,
        output iM1_REQ, iM1_MASK, iM1_RW, iM1_ADDR, iM1_DATA, iM1_BUSY,
        input  oM1_BUSY, oM1_VALID, oM1_DATA,
        input  oMIF_REQ, oMIF_MASK, oMIF_RW, oMIF_ADDR, oMIF_DATA, oMIF_BUSY,
        output iMIF_BUSY, iMIF_VALID, iMIF_DATA,
        input  oARB_ERROR
    );
endinterface

// File: rtl/memory_if_arbiter.sv
// Two-master (fetch M0, load/store M1) arbiter onto the single memory_if CPU port, with read-return steering.
// Latency: 0 cycles on both request and return paths; grant/tag/error state updates on the next rising edge.
// Backpressure: iMIF_BUSY (or a full tag FIFO for reads) holds the master via oMx_BUSY; the head master's BUSY is forwarded as oMIF_BUSY.
//
// Ports: iCLOCK (rising edge), inRESET (async, active-low), iRESET_SYNC (synchronous flush),
//        bus (memory_if_arbiter_if.slave): M0/M1 request + return channels, memory_if request + return channel, oARB_ERROR.
// Build option: define MEMORY_IF_ARBITER_M0_PRIORITY_EN for fixed M0 priority instead of round-robin.
module memory_if_arbiter #(
    parameter int TAG_DEPTH = 32,
    parameter int TAG_N     = 5
) (
    input  logic                iCLOCK,
    input  logic                inRESET,
    input  logic                iRESET_SYNC,
    memory_if_arbiter_if.slave  bus
);

    localparam logic [TAG_N:0]   CNT_FULL = (TAG_N+1)'(TAG_DEPTH);
    localparam logic [TAG_N:0]   CNT_ONE  = (TAG_N+1)'(1);
    localparam logic [TAG_N-1:0] PTR_ONE  = TAG_N'(1);

    // Tag FIFO: one bit per outstanding read, 0 = M0, 1 = M1.
    logic             tag_mem_q [TAG_DEPTH];
    logic [TAG_N:0]   count_q,  count_d;
    logic [TAG_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAG_N-1:0] rd_ptr_q, rd_ptr_d;
    logic             err_q,    err_d;
`ifndef MEMORY_IF_ARBITER_M0_PRIORITY_EN
    // Master accepted most recently; 1 = M1 so that M0 wins the first conflict.
    logic             last_grant_q, last_grant_d;
`endif

    logic tag_full, tag_empty;
    logic m0_elig, m1_elig;
    logic gnt0, gnt1;
    logic acc0, acc1;
    logic push, push_id, pop;
    logic head_id, ret_busy;

    always_comb begin
        tag_full  = (count_q == CNT_FULL);
        tag_empty = (count_q == '0);

        // Writes never need a tag, so they stay eligible with the FIFO full.
        m0_elig = bus.iM0_REQ && (bus.iM0_RW || !tag_full);
        m1_elig = bus.iM1_REQ && (bus.iM1_RW || !tag_full);

`ifdef MEMORY_IF_ARBITER_M0_PRIORITY_EN
        gnt1 = m1_elig && !m0_elig;
`else
        gnt1 = m1_elig && (!m0_elig || !last_grant_q);
`endif
        gnt0 = m0_elig && !gnt1;

        acc0 = gnt0 && !bus.iMIF_BUSY;
        acc1 = gnt1 && !bus.iMIF_BUSY;

        push    = (acc0 && !bus.iM0_RW) || (acc1 && !bus.iM1_RW);
        push_id = acc1;

        head_id  = tag_mem_q[rd_ptr_q];
        ret_busy = !tag_empty && (head_id ? bus.iM1_BUSY : bus.iM0_BUSY);
        // A word arriving with no outstanding tag is swallowed, never popped.
        pop      = bus.iMIF_VALID && !tag_empty && !ret_busy;
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q || (bus.iMIF_VALID && tag_empty);
`ifndef MEMORY_IF_ARBITER_M0_PRIORITY_EN
        last_grant_d = last_grant_q;
        if (acc0)      last_grant_d = 1'b0;
        else if (acc1) last_grant_d = 1'b1;
`endif
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (iRESET_SYNC) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            err_d    = 1'b0;
`ifndef MEMORY_IF_ARBITER_M0_PRIORITY_EN
            last_grant_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
`ifndef MEMORY_IF_ARBITER_M0_PRIORITY_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
`ifndef MEMORY_IF_ARBITER_M0_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Tag storage needs no reset: entries are only read below the count.
    always_ff @(posedge iCLOCK) begin
        if (push) tag_mem_q[wr_ptr_q] <= push_id;
    end

    // Request side
    assign bus.oM0_BUSY  = !acc0;
    assign bus.oM1_BUSY  = !acc1;
    assign bus.oMIF_REQ  = gnt0 || gnt1;
    assign bus.oMIF_MASK = gnt1 ? bus.iM1_MASK : bus.iM0_MASK;
    assign bus.oMIF_RW   = gnt1 ? bus.iM1_RW   : bus.iM0_RW;
    assign bus.oMIF_ADDR = gnt1 ? bus.iM1_ADDR : bus.iM0_ADDR;
    assign bus.oMIF_DATA = gnt1 ? bus.iM1_DATA : bus.iM0_DATA;

    // Return side
    assign bus.oM0_VALID  = bus.iMIF_VALID && !tag_empty && !head_id;
    assign bus.oM1_VALID  = bus.iMIF_VALID && !tag_empty &&  head_id;
    assign bus.oM0_DATA   = bus.iMIF_DATA;
    assign bus.oM1_DATA   = bus.iMIF_DATA;
    assign bus.oMIF_BUSY  = ret_busy;
    assign bus.oARB_ERROR = err_q;

endmodule
